// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock-enable generator: clk_out high ceil(D/2), low floor(D/2), tick on each rise.
// Latency: en sampled in IDLE -> clk_out/tick high the next cycle; no backpressure, divisor changes land on period boundaries.
module clk_div_prog #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       div_load,
    input  logic [CHANNELS*WIDTH-1:0] div_in,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           r_state;
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_div;
        logic [WIDTH-1:0] r_pend;
        logic             r_pend_vld;
        logic             r_clk;
        logic             r_tick;
        logic             r_busy;

        logic [WIDTH-1:0] w_din;
        logic [WIDTH-1:0] w_load_div;
        logic [WIDTH-1:0] w_next_div;
        logic [WIDTH-1:0] w_h_last;
        logic [WIDTH-1:0] w_l_last;
        logic             w_bound;
        logic             w_start;

        always_comb begin
            w_din      = div_in[g*WIDTH +: WIDTH];
            w_load_div = (w_din < MIN_DIV) ? MIN_DIV : w_din;
            // A write on the starting edge wins over any older pending value.
            w_next_div = div_load[g] ? w_load_div : (r_pend_vld ? r_pend : r_div);
            w_h_last   = (r_div - ONE) >> 1;
            w_l_last   = (r_div >> 1) - ONE;
            w_bound    = (r_state == S_LOW) && (r_cnt == w_l_last);
            w_start    = en[g] && ((r_state == S_IDLE) || w_bound);
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_div      <= DEF_DIV;
                r_pend     <= DEF_DIV;
                r_pend_vld <= 1'b0;
                r_clk      <= 1'b0;
                r_tick     <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                r_tick <= 1'b0;
                if (div_load[g]) begin
                    r_pend     <= w_load_div;
                    r_pend_vld <= 1'b1;
                end
                if (w_start) begin
                    r_state    <= S_HIGH;
                    r_cnt      <= '0;
                    r_div      <= w_next_div;
                    r_pend_vld <= 1'b0;
                    r_clk      <= 1'b1;
                    r_tick     <= 1'b1;
                    r_busy     <= 1'b1;
                end else begin
                    case (r_state)
                        S_IDLE: ;
                        S_HIGH: begin
                            if (r_cnt == w_h_last) begin
                                r_state <= S_LOW;
                                r_cnt   <= '0;
                                r_clk   <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + ONE;
                            end
                        end
                        S_LOW: begin
                            if (w_bound) begin
                                r_state <= S_IDLE;
                                r_cnt   <= '0;
                                r_busy  <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + ONE;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            r_clk   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign clk_out[g] = r_clk;
        assign tick[g]    = r_tick;
        assign busy[g]    = r_busy;
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog: period-position reference model feeding a scoreboard queue.
module tb_clk_div_prog;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [CH-1:0]   en;
    logic [CH-1:0]   div_load;
    logic [CH*W-1:0] div_in;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   busy;

    always #5 clk = ~clk;

    clk_div_prog #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .div_load (div_load),
        .div_in   (div_in),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy)
    );

    // Model: position within the current period, high while pos < ceil(D/2).
    int m_run  [CH];
    int m_pos  [CH];
    int m_d    [CH];
    int m_pend [CH];
    int m_pv   [CH];
    logic [CH-1:0] e_clk, e_tick, e_busy;
    logic [3*CH-1:0] sb_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int tick_cnt [CH];
    logic [CH-1:0] last_clk, last_tick;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            int din;
            int cv;
            bit bnd;
            din = int'(div_in[c*W +: W]);
            cv  = (din < 2) ? 2 : din;
            if (!reset_n) begin
                m_run[c] = 0; m_pos[c] = 0; m_d[c] = 2; m_pv[c] = 0;
                e_clk[c] = 1'b0; e_tick[c] = 1'b0; e_busy[c] = 1'b0;
            end else begin
                bnd = (m_run[c] == 0) || (m_pos[c] == m_d[c] - 1);
                if (bnd && en[c]) begin
                    m_d[c]   = div_load[c] ? cv : (m_pv[c] != 0 ? m_pend[c] : m_d[c]);
                    m_pv[c]  = 0;
                    m_run[c] = 1;
                    m_pos[c] = 0;
                end else begin
                    if (div_load[c]) begin
                        m_pend[c] = cv;
                        m_pv[c]   = 1;
                    end
                    if (bnd) m_run[c] = 0;
                    else     m_pos[c] = m_pos[c] + 1;
                end
                e_clk[c]  = (m_run[c] != 0) && (m_pos[c] < (m_d[c] + 1) / 2);
                e_tick[c] = bnd && en[c];
                e_busy[c] = (m_run[c] != 0);
            end
        end
    endtask

    task automatic cycle();
        logic [3*CH-1:0] exp_v;
        model_step();
        sb_q.push_back({e_clk, e_tick, e_busy});
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        chk("clk_out", 32'(clk_out), 32'(exp_v[3*CH-1:2*CH]));
        chk("tick",    32'(tick),    32'(exp_v[2*CH-1:CH]));
        chk("busy",    32'(busy),    32'(exp_v[CH-1:0]));
        last_clk  = clk_out;
        last_tick = tick;
        for (int c = 0; c < CH; c++) tick_cnt[c] += int'(tick[c]);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic load(input int c, input logic [W-1:0] v);
        div_load[c]       = 1'b1;
        div_in[c*W +: W]  = v;
        cycle();
        div_load[c]       = 1'b0;
    endtask

    initial begin
        int t0;
        int hi;
        bit seen;
        for (int c = 0; c < CH; c++) begin
            m_run[c] = 0; m_pos[c] = 0; m_d[c] = 2; m_pend[c] = 2; m_pv[c] = 0;
            tick_cnt[c] = 0;
        end
        reset_n  = 1'b0;
        en       = '0;
        div_load = '0;
        div_in   = '0;
        run(2);
        reset_n = 1'b1;
        run(2);

        // Default divisor on channel 0.
        en[0] = 1'b1;
        t0 = tick_cnt[0];
        run(8);
        chk("ch0_d2_ticks", 32'(tick_cnt[0] - t0), 32'd4);
        en[0] = 1'b0;
        run(3);

        // D=5 loaded while idle on channel 1.
        load(1, 8'd5);
        run(2);
        en[1] = 1'b1;
        t0 = tick_cnt[1];
        run(15);
        chk("ch1_d5_ticks", 32'(tick_cnt[1] - t0), 32'd3);
        chk("ch1_only_ticks", 32'(tick_cnt[2] + tick_cnt[3]), 32'd0);

        // D=4 then a change to 7 during the second high cycle.
        load(2, 8'd4);
        en[2] = 1'b1;
        cycle();
        cycle();
        load(2, 8'd7);
        t0 = tick_cnt[2];
        run(16);
        chk("ch2_4to7_ticks", 32'(tick_cnt[2] - t0), 32'd3);
        en[2] = 1'b0;
        run(8);

        // Clamp of 0 and 1, then 255.
        load(3, 8'd0);
        en[3] = 1'b1;
        run(6);
        load(3, 8'd1);
        run(6);
        load(3, 8'd255);
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            cycle();
            if (last_tick[3] && i > 4) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ch3_d255_tick_seen", 32'(seen), 32'd1);
        hi = int'(last_clk[3]);
        for (int i = 0; i < 254; i++) begin
            cycle();
            hi += int'(last_clk[3]);
        end
        chk("ch3_d255_high_cycles", 32'(hi), 32'd128);
        en[3] = 1'b0;
        run(260);

        // Stop during HIGH with D=6, then drop/raise within a period.
        load(0, 8'd6);
        en[0] = 1'b1;
        cycle();
        en[0] = 1'b0;
        t0 = tick_cnt[0];
        run(10);
        chk("ch0_stop_no_extra_tick", 32'(tick_cnt[0] - t0), 32'd0);
        chk("ch0_stop_busy", 32'(busy[0]), 32'd0);
        en[0] = 1'b1;
        run(3);
        en[0] = 1'b0;
        run(1);
        en[0] = 1'b1;
        t0 = tick_cnt[0];
        run(12);
        chk("ch0_no_gap_ticks", 32'(tick_cnt[0] - t0), 32'd2);

        // Reset mid-HIGH with several channels running, en held high.
        en = 4'b1011;
        load(1, 8'd9);
        run(12);
        reset_n = 1'b0;
        cycle();
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        reset_n = 1'b1;
        t0 = tick_cnt[0];
        run(8);
        chk("ch0_default_after_rst", 32'(tick_cnt[0] - t0), 32'd4);
        en = '0;
        run(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
